// File: rtl/tile_layer_controller_if.sv
// Bundle of the control, DMA-stream, array and PPU signals of tile_layer_controller.
// master: the controller itself; slave: the datapath/DMA side that drives its inputs.
interface tile_layer_controller_if #(
    parameter int ADDR_W = 12,
    parameter int TILE_W = 8
);
    logic              start;
    logic              abort;
    logic [TILE_W-1:0] cfg_tiles;
    logic              cfg_reuse;
    logic              dram_valid;
    logic              valid_array;
    logic              ppu_ready;
    logic [ADDR_W-1:0] data_address;
    logic              ifmap_wen;
    logic              weight_wen;
    logic              bias_wen;
    logic              ifmap_ren;
    logic              weight_ren;
    logic              bias_ren;
    logic              i_en_array;
    logic              i_en_ppu;
    logic              ofmap_ren;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;
    logic [31:0]       perf_cycles;

    modport master (
        input  start, abort, cfg_tiles, cfg_reuse, dram_valid, valid_array, ppu_ready,
        output data_address, ifmap_wen, weight_wen, bias_wen, ifmap_ren, weight_ren, bias_ren,
               i_en_array, i_en_ppu, ofmap_ren, tile_idx, busy, done, perf_cycles
    );

    modport slave (
        output start, abort, cfg_tiles, cfg_reuse, dram_valid, valid_array, ppu_ready,
        input  data_address, ifmap_wen, weight_wen, bias_wen, ifmap_ren, weight_ren, bias_ren,
               i_en_array, i_en_ppu, ofmap_ren, tile_idx, busy, done, perf_cycles
    );
endinterface

// File: rtl/tile_layer_controller.sv
// Multi-tile sequencer: streams ifmap/weight/bias words into the GLB, counts ARRAY_TIMES
// systolic passes, drains the ofmap through the PPU under backpressure, and repeats for
// each output tile (optionally keeping the ifmap resident across tiles).
// Optional feature: define PERF_CNT_EN to get a saturating busy-cycle counter on
// perf_cycles; without it the port is tied to zero.
module tile_layer_controller #(
    parameter int WIDTH       = 64,
    parameter int ARRAY_TIMES = 16,
    parameter int ADDR_W      = 12,
    parameter int TILE_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tile_layer_controller_if.master   bus
);
    localparam int IFMAP_WORDS  = WIDTH / 4;
    localparam int WEIGHT_WORDS = WIDTH * WIDTH / 4;
    localparam int BIAS_WORDS   = WIDTH;
    localparam int OFMAP_WORDS  = WIDTH;

    // Terminal values compared exactly, so address/pass counters never need to wrap.
    localparam logic [ADDR_W-1:0] IFMAP_LAST  = ADDR_W'(IFMAP_WORDS - 1);
    localparam logic [ADDR_W-1:0] WEIGHT_LAST = ADDR_W'(WEIGHT_WORDS - 1);
    localparam logic [ADDR_W-1:0] BIAS_LAST   = ADDR_W'(BIAS_WORDS - 1);
    localparam logic [ADDR_W-1:0] PASS_LAST   = ADDR_W'(ARRAY_TIMES - 1);
    localparam logic [ADDR_W-1:0] OFMAP_LAST  = ADDR_W'(OFMAP_WORDS - 1);

    // The address bus doubles as the pass counter in ARRAY, so it must hold both ranges.
    if (ADDR_W < $clog2(WEIGHT_WORDS) || ADDR_W < $clog2(ARRAY_TIMES)) begin : g_addr_w_check
        $error("tile_layer_controller: ADDR_W too narrow for WEIGHT_WORDS/ARRAY_TIMES");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LD_IFMAP, S_LD_WEIGHT, S_LD_BIAS, S_ARRAY, S_PPU, S_DONE
    } state_t;

    state_t            state;
    logic [TILE_W-1:0] tiles_q;
    logic              reuse_q;
    logic [TILE_W-1:0] last_tile;
    logic              start_ok;

    // A tile count of zero runs a single tile.
    assign last_tile = (tiles_q == '0) ? '0 : tiles_q - 1'b1;
    assign start_ok  = ((state == S_IDLE) || (state == S_DONE)) && bus.start;

    // GLB write strobes follow the incoming DRAM stream directly.
    assign bus.ifmap_wen  = (state == S_LD_IFMAP)  & bus.dram_valid;
    assign bus.weight_wen = (state == S_LD_WEIGHT) & bus.dram_valid;
    assign bus.bias_wen   = (state == S_LD_BIAS)   & bus.dram_valid;

    // Sequencer FSM with registered control outputs; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            tiles_q          <= '0;
            reuse_q          <= 1'b0;
            bus.data_address <= '0;
            bus.tile_idx     <= '0;
            bus.ifmap_ren    <= 1'b0;
            bus.weight_ren   <= 1'b0;
            bus.bias_ren     <= 1'b0;
            bus.i_en_array   <= 1'b0;
            bus.i_en_ppu     <= 1'b0;
            bus.ofmap_ren    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else if (bus.abort) begin
            state            <= S_IDLE;
            bus.data_address <= '0;
            bus.tile_idx     <= '0;
            bus.ifmap_ren    <= 1'b0;
            bus.weight_ren   <= 1'b0;
            bus.bias_ren     <= 1'b0;
            bus.i_en_array   <= 1'b0;
            bus.i_en_ppu     <= 1'b0;
            bus.ofmap_ren    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state            <= S_LD_IFMAP;
                        tiles_q          <= bus.cfg_tiles;
                        reuse_q          <= bus.cfg_reuse;
                        bus.tile_idx     <= '0;
                        bus.data_address <= '0;
                        bus.busy         <= 1'b1;
                        bus.done         <= 1'b0;
                    end
                end
                S_LD_IFMAP: begin
                    if (bus.dram_valid) begin
                        if (bus.data_address == IFMAP_LAST) begin
                            state            <= S_LD_WEIGHT;
                            bus.data_address <= '0;
                        end else begin
                            bus.data_address <= bus.data_address + 1'b1;
                        end
                    end
                end
                S_LD_WEIGHT: begin
                    if (bus.dram_valid) begin
                        if (bus.data_address == WEIGHT_LAST) begin
                            state            <= S_LD_BIAS;
                            bus.data_address <= '0;
                        end else begin
                            bus.data_address <= bus.data_address + 1'b1;
                        end
                    end
                end
                S_LD_BIAS: begin
                    if (bus.dram_valid) begin
                        if (bus.data_address == BIAS_LAST) begin
                            state            <= S_ARRAY;
                            bus.data_address <= '0;
                            bus.ifmap_ren    <= 1'b1;
                            bus.weight_ren   <= 1'b1;
                            bus.bias_ren     <= 1'b1;
                            bus.i_en_array   <= 1'b1;
                        end else begin
                            bus.data_address <= bus.data_address + 1'b1;
                        end
                    end
                end
                S_ARRAY: begin
                    if (bus.valid_array) begin
                        if (bus.data_address == PASS_LAST) begin
                            state            <= S_PPU;
                            bus.data_address <= '0;
                            bus.ifmap_ren    <= 1'b0;
                            bus.weight_ren   <= 1'b0;
                            bus.bias_ren     <= 1'b0;
                            bus.i_en_array   <= 1'b0;
                            bus.ofmap_ren    <= 1'b1;
                            bus.i_en_ppu     <= 1'b1;
                        end else begin
                            bus.data_address <= bus.data_address + 1'b1;
                        end
                    end
                end
                S_PPU: begin
                    if (bus.ppu_ready) begin
                        if (bus.data_address == OFMAP_LAST) begin
                            bus.data_address <= '0;
                            bus.ofmap_ren    <= 1'b0;
                            bus.i_en_ppu     <= 1'b0;
                            if (bus.tile_idx == last_tile) begin
                                state    <= S_DONE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end else begin
                                bus.tile_idx <= bus.tile_idx + 1'b1;
                                state        <= reuse_q ? S_LD_WEIGHT : S_LD_IFMAP;
                            end
                        end else begin
                            bus.data_address <= bus.data_address + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Busy-cycle counter: restarts with each job, saturates, and holds once the job is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.perf_cycles <= '0;
        end else if (bus.abort || start_ok) begin
            bus.perf_cycles <= '0;
        end else if (bus.busy && (bus.perf_cycles != 32'hFFFF_FFFF)) begin
            bus.perf_cycles <= bus.perf_cycles + 32'd1;
        end
    end
`else
    assign bus.perf_cycles = 32'd0;
`endif
endmodule
